// File: rtl/axis_pattern_gen.sv
// AXI-Stream master emitting bursts of incrementing-data packets with TLAST framing.
// All outputs are registered; the handshake only steers next-state logic.
//
// state | meaning
// IDLE  | waiting for start; inputs latched on start
// SEND  | tvalid high, beats presented until handshake
// GAP   | tvalid low for gap_cycles cycles between packets
// FIN   | one-cycle done pulse, then back to IDLE
module axis_pattern_gen #(
  parameter int DATA_WIDTH = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  m_axis_clk,
  input  logic                  m_axis_rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0]  beat_count,
  input  logic [7:0]            pkt_count,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           tx_beats,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  beats_len, beats_len_nxt;
  logic [LEN_WIDTH-1:0]  beats_left, beats_left_nxt;
  logic [7:0]            pkts_left, pkts_left_nxt;
  logic [GAP_WIDTH-1:0]  gap_len, gap_len_nxt;
  logic [GAP_WIDTH-1:0]  gap_left, gap_left_nxt;
  logic                  busy_nxt, done_nxt, tvalid_nxt, tlast_nxt;
  logic [15:0]           tx_beats_nxt;
  logic [DATA_WIDTH-1:0] tdata_nxt;

  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      state         <= IDLE;
      beats_len     <= '0;
      beats_left    <= '0;
      pkts_left     <= '0;
      gap_len       <= '0;
      gap_left      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tx_beats      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state         <= state_nxt;
      beats_len     <= beats_len_nxt;
      beats_left    <= beats_left_nxt;
      pkts_left     <= pkts_left_nxt;
      gap_len       <= gap_len_nxt;
      gap_left      <= gap_left_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      tx_beats      <= tx_beats_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tlast  <= tlast_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    beats_len_nxt  = beats_len;
    beats_left_nxt = beats_left;
    pkts_left_nxt  = pkts_left;
    gap_len_nxt    = gap_len;
    gap_left_nxt   = gap_left;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    tx_beats_nxt   = tx_beats;
    tvalid_nxt     = m_axis_tvalid;
    tdata_nxt      = m_axis_tdata;
    tlast_nxt      = m_axis_tlast;

    case (state)
      IDLE: begin
        if (start) begin
          beats_len_nxt  = beat_count;
          beats_left_nxt = beat_count;
          pkts_left_nxt  = pkt_count;
          gap_len_nxt    = gap_cycles;
          tx_beats_nxt   = '0;
          if (beat_count == '0 || pkt_count == '0) begin
            // Empty run: skip straight to the done pulse, never look busy.
            state_nxt = FIN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt  = SEND;
            busy_nxt   = 1'b1;
            tvalid_nxt = 1'b1;
            tdata_nxt  = seed;
            tlast_nxt  = (beat_count == LEN_WIDTH'(1));
          end
        end
      end

      SEND: begin
        if (m_axis_tready) begin
          tx_beats_nxt = tx_beats + 16'd1;
          tdata_nxt    = m_axis_tdata + DATA_WIDTH'(1);
          if (beats_left == LEN_WIDTH'(1)) begin
            beats_left_nxt = beats_len;
            pkts_left_nxt  = pkts_left - 8'd1;
            if (pkts_left == 8'd1) begin
              state_nxt  = FIN;
              tvalid_nxt = 1'b0;
              tlast_nxt  = 1'b0;
              busy_nxt   = 1'b0;
              done_nxt   = 1'b1;
            end else if (gap_len == '0) begin
              tlast_nxt = (beats_len == LEN_WIDTH'(1));
            end else begin
              state_nxt    = GAP;
              tvalid_nxt   = 1'b0;
              tlast_nxt    = 1'b0;
              gap_left_nxt = gap_len;
            end
          end else begin
            beats_left_nxt = beats_left - LEN_WIDTH'(1);
            tlast_nxt      = (beats_left == LEN_WIDTH'(2));
          end
        end
      end

      GAP: begin
        if (gap_left == GAP_WIDTH'(1)) begin
          state_nxt  = SEND;
          tvalid_nxt = 1'b1;
          tlast_nxt  = (beats_len == LEN_WIDTH'(1));
        end else begin
          gap_left_nxt = gap_left - GAP_WIDTH'(1);
        end
      end

      FIN: begin
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Bench for axis_pattern_gen: table of runs checked against a beat scoreboard,
// plus hand sequences for ignored start and mid-run reset.
module tb_axis_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  seed = '0;
  logic [7:0]  beat_count = '0;
  logic [7:0]  pkt_count = '0;
  logic [3:0]  gap_cycles = '0;
  logic        busy, done, tvalid, tlast;
  logic        tready = 1'b0;
  logic [15:0] tx_beats;
  logic [3:0]  tdata;

  axis_pattern_gen dut (
    .m_axis_clk    (clk),
    .m_axis_rst_n  (rst_n),
    .start         (start),
    .seed          (seed),
    .beat_count    (beat_count),
    .pkt_count     (pkt_count),
    .gap_cycles    (gap_cycles),
    .busy          (busy),
    .done          (done),
    .tx_beats      (tx_beats),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tlast  (tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [3:0] seed;
    logic [7:0] beats;
    logic [7:0] pkts;
    logic [3:0] gap;
    int         mode;
    bit         mid_start;
    int         exp_tx;
  } vec_t;

  beat_t sbq[$];
  vec_t  vecs[9];
  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  int    rdy_mode = 0;
  int    rdy_cyc = 0;
  int    exp_gap = 0;
  bit    exp_zero = 0;

  // tready pattern: 0 = always high, 1 = 1,0,0 repeating, 2 = random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tready = 1'b1;
      1:       tready = (rdy_cyc % 3 == 0);
      default: tready = 1'($urandom_range(0, 1));
    endcase
    rdy_cyc++;
  end

  bit         prev_stall = 0, hs_last = 0, done_prev = 0;
  logic [3:0] prev_data = '0;
  logic       prev_last = 0;
  int         low_run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      hs_last    = 0;
      done_prev  = 0;
      low_run    = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(tvalid && tdata == prev_data && tlast == prev_last)) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b, want v=1 d=%0h l=%0b",
                   tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (busy || done_prev || (!exp_zero && !hs_last)) begin
          errors++;
          $display("FAIL done_pulse: got busy=%0b prev_done=%0b prev_last_hs=%0b, want 0,0,%0b",
                   busy, done_prev, hs_last, !exp_zero);
        end
      end
      if (exp_zero) begin
        checks++;
        if (busy || tvalid) begin
          errors++;
          $display("FAIL zero_run_idle: got busy=%0b tvalid=%0b, want 0,0", busy, tvalid);
        end
      end
      if (busy && !tvalid) low_run++;
      else if (tvalid && low_run > 0) begin
        checks++;
        if (low_run != exp_gap) begin
          errors++;
          $display("FAIL gap_len: got %0d, want %0d", low_run, exp_gap);
        end
        low_run = 0;
      end
      if (tvalid && tready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got d=%0h l=%0b, want no beat", tdata, tlast);
        end else begin
          beat_t e;
          e = sbq.pop_front();
          if (tdata != e.data || tlast != e.last) begin
            errors++;
            $display("FAIL beat: got d=%0h l=%0b, want d=%0h l=%0b", tdata, tlast, e.data, e.last);
          end
        end
      end
      hs_last    = tvalid && tready && tlast;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      done_prev  = done;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic push_run(input logic [3:0] s, input int beats, input int pkts);
    int idx = 0;
    for (int p = 0; p < pkts; p++)
      for (int b = 0; b < beats; b++) begin
        beat_t e;
        e.data = 4'(int'(s) + idx);
        e.last = (b == beats - 1);
        sbq.push_back(e);
        idx++;
      end
  endtask

  task automatic run_cfg(input vec_t v);
    int  start_cnt;
    bit  got_done = 0;
    rdy_mode = v.mode;
    exp_gap  = int'(v.gap);
    push_run(v.seed, int'(v.beats), int'(v.pkts));
    @(posedge clk); #1;
    exp_zero   = (v.beats == 0 || v.pkts == 0);
    seed       = v.seed;
    beat_count = v.beats;
    pkt_count  = v.pkts;
    gap_cycles = v.gap;
    start      = 1'b1;
    start_cnt  = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    if (exp_zero) begin
      chk("zero_busy", int'(busy), 0);
    end else begin
      chk("first_valid", int'(tvalid), 1);
      chk("first_data", int'(tdata), int'(v.seed));
      chk("first_last", int'(tlast), int'(v.beats == 1));
      chk("first_busy", int'(busy), 1);
    end
    for (int c = 0; c < 400; c++) begin
      if (done_cnt > start_cnt) begin
        got_done = 1;
        break;
      end
      start = v.mid_start && (c == 3);
      if (start) begin
        seed       = 4'hA;
        beat_count = 8'd1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!got_done) begin
      errors++;
      $display("FAIL run_timeout: got no done, want done within 400 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    chk("tx_beats", int'(tx_beats), v.exp_tx);
    chk("queue_drained", sbq.size(), 0);
    chk("done_count", done_cnt - start_cnt, 1);
    chk("idle_busy", int'(busy), 0);
    exp_zero = 0;
    sbq.delete();
  endtask

  initial begin
    int dc;
    vecs[0] = '{4'd3,  8'd4, 8'd1, 4'd0, 0, 1'b0, 4};
    vecs[1] = '{4'd3,  8'd4, 8'd1, 4'd0, 1, 1'b0, 4};
    vecs[2] = '{4'd14, 8'd4, 8'd1, 4'd0, 0, 1'b0, 4};
    vecs[3] = '{4'd0,  8'd2, 8'd3, 4'd2, 0, 1'b0, 6};
    vecs[4] = '{4'd5,  8'd0, 8'd5, 4'd0, 0, 1'b0, 0};
    vecs[5] = '{4'd7,  8'd3, 8'd0, 4'd1, 0, 1'b0, 0};
    vecs[6] = '{4'd9,  8'd1, 8'd4, 4'd0, 2, 1'b0, 4};
    vecs[7] = '{4'd2,  8'd5, 8'd2, 4'd3, 1, 1'b1, 10};
    vecs[8] = '{4'd15, 8'd1, 8'd3, 4'd1, 0, 1'b0, 3};

    #1;
    chk("rst_tvalid", int'(tvalid), 0);
    chk("rst_tdata", int'(tdata), 0);
    chk("rst_tlast", int'(tlast), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tx_beats", int'(tx_beats), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_cfg(vecs[i]);

    // Mid-packet reset: outputs clear at once, no done pulse, then a clean run.
    rdy_mode = 0;
    exp_gap  = 0;
    push_run(4'd4, 8, 2);
    @(posedge clk); #1;
    seed = 4'd4; beat_count = 8'd8; pkt_count = 8'd2; gap_cycles = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = done_cnt;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_tvalid", int'(tvalid), 0);
    chk("mrst_tlast", int'(tlast), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_tdata", int'(tdata), 0);
    sbq.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mrst_no_done", done_cnt - dc, 0);
    chk("mrst_idle_valid", int'(tvalid), 0);
    run_cfg(vecs[3]);
    run_cfg(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
